// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32IM instruction-fetch stage.
package fetch_pkg;

    // Datapath and instruction-memory geometry defaults.
    localparam int          FETCH_XLEN     = 32;
    localparam int          FETCH_IMEM_AW  = 6;
    localparam int          FETCH_INST_W   = 32;
    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // Canonical no-op (add x0,x0,x0) shown to decode while the buffer is empty.
    localparam logic [31:0] FETCH_INST_NOP = 32'h0000_0033;

    // Fetch-entry layout: {pc, inst}, pc in the upper bits.
    localparam int ENTRY_PC_W   = FETCH_XLEN;
    localparam int ENTRY_INST_W = FETCH_INST_W;
    localparam int ENTRY_W      = ENTRY_PC_W + ENTRY_INST_W;

    // Fetch sequencer states.
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    // A redirect target is unusable unless it is word aligned.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return addr_lo != 2'b00;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO buffering fetched {pc, inst} entries for decode.
// Head is read straight from the storage array so a pushed entry is visible
// the cycle after the push. Clear wins over push and pop.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clear,
    input  logic [W-1:0]             i_data,
    output logic [W-1:0]             o_head,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic w_empty;
    logic w_full;
    logic w_do_pop;
    logic w_do_push;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_do_pop  = i_pop && !w_empty && !i_clear;
    // A full buffer may still accept a push when its head leaves this cycle.
    assign w_do_push = i_push && !i_clear && (!w_full || w_do_pop);

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    // Entry storage: data only, no reset needed since count gates visibility.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// RV32IM instruction fetch: owns the PC, reads the combinational instruction
// memory, buffers {pc, inst} for decode and obeys redirects from execute.
// A misaligned redirect parks the stage in HALT with a sticky fault until reset.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int              XLEN       = FETCH_XLEN,
    parameter int              IMEM_AW    = FETCH_IMEM_AW,
    parameter logic [XLEN-1:0] RESET_PC   = XLEN'(FETCH_RESET_PC),
    parameter int              FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] o_imem_addr,
    input  logic [31:0]        i_imem_data,
    input  logic               i_redirect_valid,
    input  logic [XLEN-1:0]    i_redirect_pc,
    output logic               o_out_valid,
    input  logic               i_out_ready,
    output logic [31:0]        o_out_inst,
    output logic [XLEN-1:0]    o_out_pc,
    output logic [XLEN-1:0]    o_out_pc_plus4,
    output logic               o_fetch_fault
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int EW = XLEN + FETCH_INST_W;

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic            r_fault;

    logic [CW-1:0]   w_count;
    logic [EW-1:0]   w_head;
    logic            w_empty;
    logic            w_full;
    logic            w_pop;
    logic            w_run;
    logic            w_redirect;
    logic            w_misaligned;
    logic            w_push;

    assign w_empty      = (w_count == '0);
    assign w_full       = (w_count == CW'(FIFO_DEPTH));
    assign w_pop        = !w_empty && i_out_ready;
    assign w_run        = (r_state == ST_RUN);
    assign w_redirect   = w_run && i_redirect_valid;
    assign w_misaligned = is_misaligned(i_redirect_pc[1:0]);
    // Redirect outranks the sequential fetch; the word read this cycle is dropped.
    assign w_push       = w_run && !i_redirect_valid && (!w_full || w_pop);

    assign o_imem_addr   = r_pc[IMEM_AW+1:2];
    assign o_fetch_fault = r_fault;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_clear (w_redirect),
        .i_data  ({r_pc, i_imem_data}),
        .o_head  (w_head),
        .o_count (w_count)
    );

    // Sequencer: state, PC and sticky fault updated together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_BOOT;
            r_pc    <= RESET_PC;
            r_fault <= 1'b0;
        end else begin
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (i_redirect_valid) begin
                        if (w_misaligned) begin
                            r_pc    <= {i_redirect_pc[XLEN-1:2], 2'b00};
                            r_state <= ST_HALT;
                            r_fault <= 1'b1;
                        end else begin
                            r_pc <= i_redirect_pc;
                        end
                    end else if (w_push) begin
                        r_pc <= r_pc + XLEN'(4);
                    end
                end
                ST_HALT: begin
                    r_state <= ST_HALT;
                end
                default: begin
                    r_state <= ST_HALT;
                end
            endcase
        end
    end

    // Decode-facing view of the buffer head; a NOP at PC 0 while empty.
    always_comb begin
        o_out_valid = !w_empty;
        o_out_pc    = '0;
        o_out_inst  = FETCH_INST_NOP;
        if (!w_empty) begin
            o_out_pc   = w_head[EW-1 -: XLEN];
            o_out_inst = w_head[FETCH_INST_W-1:0];
        end
    end

    assign o_out_pc_plus4 = o_out_pc + XLEN'(4);

endmodule
